// File: rtl/ld_alloc.sv
// rtl/ld_alloc.sv - lowest-index free-slot allocator for the linked_data table
// Offers one free, unreserved entry per cycle on a registered valid/ready stream.
module ld_alloc #(
    parameter int MaxWrTxns = 16,
    parameter int IdxWidth  = $clog2(MaxWrTxns),
    parameter int CntWidth  = $clog2(MaxWrTxns + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MaxWrTxns-1:0] linked_data_free_i,
    output logic                 idx_valid_o,
    input  logic                 idx_ready_i,
    output logic [IdxWidth-1:0]  idx_o,
    output logic [CntWidth-1:0]  free_cnt_o,
    output logic                 full_o
);

    localparam logic [MaxWrTxns-1:0] OneHot0 = MaxWrTxns'(1);

    logic [MaxWrTxns-1:0] reserved_q, reserved_d;
    logic                 idx_valid_q, idx_valid_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [CntWidth-1:0]  free_cnt_q, free_cnt_d;
    logic                 full_q, full_d;

    logic [MaxWrTxns-1:0] avail;
    logic [MaxWrTxns-1:0] offered_mask;
    logic [MaxWrTxns-1:0] grant_mask;
    logic [MaxWrTxns-1:0] clear_mask;
    logic [IdxWidth-1:0]  enc_idx;
    logic                 any_avail;
    logic                 load;
    logic                 grant;

    assign avail     = linked_data_free_i & ~reserved_q;
    assign any_avail = |avail;
    assign load      = ~idx_valid_q | idx_ready_i;
    assign grant     = load & any_avail;

    // Lowest set bit wins: scan from the top so the last hit is the smallest index.
    always_comb begin
        enc_idx = '0;
        for (int i = MaxWrTxns - 1; i >= 0; i--) begin
            if (avail[i]) begin
                enc_idx = IdxWidth'(i);
            end
        end
    end

    assign offered_mask = idx_valid_q ? (OneHot0 << idx_q) : '0;
    assign grant_mask   = grant ? (OneHot0 << enc_idx) : '0;

    // A reservation retires once the table shows the entry used, except while it is still on offer.
    assign clear_mask = ~linked_data_free_i & ~offered_mask;

    always_comb begin
        idx_valid_d = idx_valid_q;
        idx_d       = idx_q;
        if (load) begin
            idx_valid_d = any_avail;
        end
        if (grant) begin
            idx_d = enc_idx;
        end
    end

    assign reserved_d = (reserved_q & ~clear_mask) | grant_mask;

    always_comb begin
        free_cnt_d = '0;
        for (int i = 0; i < MaxWrTxns; i++) begin
            if (avail[i] && !grant_mask[i]) begin
                free_cnt_d = free_cnt_d + CntWidth'(1);
            end
        end
    end

    assign full_d = (free_cnt_d == '0) & ~idx_valid_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reserved_q  <= '0;
            idx_valid_q <= 1'b0;
            idx_q       <= '0;
            free_cnt_q  <= '0;
            full_q      <= 1'b0;
        end else begin
            reserved_q  <= reserved_d;
            idx_valid_q <= idx_valid_d;
            idx_q       <= idx_d;
            free_cnt_q  <= free_cnt_d;
            full_q      <= full_d;
        end
    end

    assign idx_valid_o = idx_valid_q;
    assign idx_o       = idx_q;
    assign free_cnt_o  = free_cnt_q;
    assign full_o      = full_q;

endmodule
